// File: rtl/ldpc_layer_scheduler_if.sv
// Scheduler <-> controller/row-unit bundle.
// master: drives start/max_iter/early_stop; slave: the scheduler.
interface ldpc_layer_scheduler_if #(
  parameter int LAYERBITS = 1,
  parameter int ADDRWIDTH = 5,
  parameter int ITERBITS  = 5
);
  logic                 start;
  logic [ITERBITS-1:0]  max_iter;
  logic                 early_stop;
  logic [LAYERBITS-1:0] rdlayer;
  logic [ADDRWIDTH-1:0] rdaddress;
  logic                 rden_LLR;
  logic                 rden_E;
  logic [ITERBITS-1:0]  iter_count;
  logic                 busy;
  logic                 done;
  logic                 stopped_early;

  modport master (
    output start, max_iter, early_stop,
    input  rdlayer, rdaddress, rden_LLR, rden_E,
    input  iter_count, busy, done, stopped_early
  );

  modport slave (
    input  start, max_iter, early_stop,
    output rdlayer, rdaddress, rden_LLR, rden_E,
    output iter_count, busy, done, stopped_early
  );
endinterface

// File: rtl/ldpc_layer_scheduler.sv
// Layered LDPC read sequencer: walks layers/addresses with hazard gaps.
// Ports: clk, rst (sync, active-low), bus (slave modport of the _if).
module ldpc_layer_scheduler #(
  parameter int LAYERS     = 2,
  parameter int LAYERBITS  = 1,
  parameter int ADDRWIDTH  = 5,
  parameter int ADDRDEPTH  = 20,
  parameter int HAZARD_GAP = 11,
  parameter int ITERBITS   = 5
) (
  input logic clk,
  input logic rst,
  ldpc_layer_scheduler_if.slave bus
);

  localparam int GAPW = $clog2(HAZARD_GAP + 1);

  typedef enum logic [2:0] {
    IDLE, READ, GAP, DRAIN, DONE
  } state_t;

  state_t               state_q, state_d;
  logic [LAYERBITS-1:0] layer_q, layer_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [GAPW-1:0]      gap_q, gap_d;
  logic [ITERBITS-1:0]  iter_q, iter_d;
  logic [ITERBITS-1:0]  maxit_q, maxit_d;
  logic                 stop_q, stop_d;

  logic [LAYERBITS-1:0] rdlayer_q, rdlayer_d;
  logic [ADDRWIDTH-1:0] rdaddr_q, rdaddr_d;
  logic                 rden_llr_q, rden_llr_d;
  logic                 rden_e_q, rden_e_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic addr_last, layer_last, gap_last, iter_last;

  assign addr_last  = addr_q == ADDRWIDTH'(ADDRDEPTH - 1);
  assign layer_last = layer_q == LAYERBITS'(LAYERS - 1);
  assign gap_last   = gap_q == GAPW'(HAZARD_GAP - 1);
  assign iter_last  = iter_q == maxit_q - ITERBITS'(1);

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    addr_d  = addr_q;
    gap_d   = gap_q;
    iter_d  = iter_q;
    maxit_d = maxit_q;
    stop_d  = stop_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = READ;
          maxit_d = (bus.max_iter == '0) ? ITERBITS'(1)
                                         : bus.max_iter;
          layer_d = '0;
          addr_d  = '0;
          iter_d  = '0;
          stop_d  = 1'b0;
        end
      end
      READ: begin
        if (addr_last) begin
          gap_d   = '0;
          state_d = layer_last ? DRAIN : GAP;
        end else begin
          addr_d = addr_q + ADDRWIDTH'(1);
        end
      end
      GAP: begin
        if (gap_last) begin
          state_d = READ;
          layer_d = layer_q + LAYERBITS'(1);
          addr_d  = '0;
        end else begin
          gap_d = gap_q + GAPW'(1);
        end
      end
      DRAIN: begin
        if (!gap_last) begin
          gap_d = gap_q + GAPW'(1);
        end else if (bus.early_stop) begin
          state_d = DONE;
          stop_d  = 1'b1;
        end else if (iter_last) begin
          state_d = DONE;
          stop_d  = 1'b0;
        end else begin
          state_d = READ;
          iter_d  = iter_q + ITERBITS'(1);
          layer_d = '0;
          addr_d  = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state so a beat appears in the
  // same cycle the FSM sits in READ for it.
  always_comb begin
    rden_llr_d = state_d == READ;
    rden_e_d   = rden_llr_d && (iter_d != '0);
    rdlayer_d  = rden_llr_d ? layer_d : rdlayer_q;
    rdaddr_d   = rden_llr_d ? addr_d : rdaddr_q;
    busy_d     = (state_d == READ) || (state_d == GAP) ||
                 (state_d == DRAIN);
    done_d     = state_d == DONE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      layer_q    <= '0;
      addr_q     <= '0;
      gap_q      <= '0;
      iter_q     <= '0;
      maxit_q    <= '0;
      stop_q     <= 1'b0;
      rdlayer_q  <= '0;
      rdaddr_q   <= '0;
      rden_llr_q <= 1'b0;
      rden_e_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      addr_q     <= addr_d;
      gap_q      <= gap_d;
      iter_q     <= iter_d;
      maxit_q    <= maxit_d;
      stop_q     <= stop_d;
      rdlayer_q  <= rdlayer_d;
      rdaddr_q   <= rdaddr_d;
      rden_llr_q <= rden_llr_d;
      rden_e_q   <= rden_e_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.rdlayer       = rdlayer_q;
  assign bus.rdaddress     = rdaddr_q;
  assign bus.rden_LLR      = rden_llr_q;
  assign bus.rden_E        = rden_e_q;
  assign bus.iter_count    = iter_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.stopped_early = stop_q;

endmodule
